// File: rtl/pll_lock_sequencer_pkg.sv
// pll_seq_pkg: state type and sizing helper shared by the PLL lock sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    RESET_PLL,
    WAIT_LOCK,
    STABILIZE,
    RUN,
    FAULT
  } seqState_e;

  // Width of the shared phase counter: it only ever has to reach (largest phase length - 1).
  function automatic int cntWidth(input int rstPulse, input int lockTimeout, input int lockStable);
    int largest;
    largest = rstPulse;
    if (lockTimeout > largest) largest = lockTimeout;
    if (lockStable > largest) largest = lockStable;
    return (largest < 2) ? 1 : $clog2(largest);
  endfunction

endpackage

// File: rtl/pll_lock_sequencer_sync_2ff.sv
// sync_2ff: single-bit two-flop synchronizer with synchronous active-high reset.
module sync_2ff (
  input  logic clock_i,
  input  logic reset_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;

  // Capture the asynchronous bit in two stages; both stages clear on reset.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      meta_q <= 1'b0;
      q_o    <= 1'b0;
    end else begin
      meta_q <= d_i;
      q_o    <= meta_q;
    end
  end

endmodule

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: drives the pixel-clock PLL reset, qualifies its lock output,
// retries failed lock attempts and latches a fault once retries are exhausted.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_PULSE_CYC    = 16,
  parameter int LOCK_TIMEOUT_CYC = 50000,
  parameter int LOCK_STABLE_CYC  = 1024,
  parameter int MAX_RETRIES      = 3
) (
  input  logic                               refclk,
  input  logic                               rst,
  input  logic                               locked_in,
  input  logic                               relock_req,
  output logic                               pll_rst,
  output logic                               clk_ready,
  output logic                               fault,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt
);

  localparam int CW = cntWidth(RST_PULSE_CYC, LOCK_TIMEOUT_CYC, LOCK_STABLE_CYC);
  localparam int RW = $clog2(MAX_RETRIES + 1);

  localparam logic [CW-1:0] RST_LAST     = CW'(RST_PULSE_CYC - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYC - 1);
  localparam logic [RW-1:0] RETRY_LIMIT  = RW'(MAX_RETRIES);

  logic          lockSync;
  seqState_e     state_q, state_d;
  logic [CW-1:0] cycleCnt_q, cycleCnt_d;
  logic [RW-1:0] retryCnt_q, retryCnt_d;
  logic          pllRst_q, clkReady_q, fault_q;

  sync_2ff uLockSync (
    .clock_i (refclk),
    .reset_i (rst),
    .d_i     (locked_in),
    .q_o     (lockSync)
  );

  // Next phase, retry bookkeeping and counter restart; rst is applied in the register block.
  always_comb begin
    state_d    = state_q;
    retryCnt_d = retryCnt_q;
    if (relock_req) begin
      state_d    = RESET_PLL;
      retryCnt_d = '0;
    end else begin
      case (state_q)
        RESET_PLL: begin
          if (cycleCnt_q == RST_LAST) state_d = WAIT_LOCK;
        end
        WAIT_LOCK: begin
          if (lockSync) begin
            state_d = STABILIZE;
          end else if (cycleCnt_q == TIMEOUT_LAST) begin
            if (retryCnt_q == RETRY_LIMIT) begin
              state_d = FAULT;
            end else begin
              state_d    = RESET_PLL;
              retryCnt_d = retryCnt_q + RW'(1);
            end
          end
        end
        STABILIZE: begin
          if (!lockSync) begin
            state_d = WAIT_LOCK;
          end else if (cycleCnt_q == STABLE_LAST) begin
            state_d    = RUN;
            retryCnt_d = '0;
          end
        end
        RUN: begin
          if (!lockSync) state_d = RESET_PLL;
        end
        FAULT: begin
          state_d = FAULT;
        end
        default: begin
          state_d = RESET_PLL;
        end
      endcase
    end
    cycleCnt_d = (relock_req || (state_d != state_q)) ? '0 : cycleCnt_q + CW'(1);
  end

  // Register the phase, counter and retry count, with Moore outputs decoded from the next phase.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q    <= RESET_PLL;
      cycleCnt_q <= '0;
      retryCnt_q <= '0;
      pllRst_q   <= 1'b1;
      clkReady_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cycleCnt_q <= cycleCnt_d;
      retryCnt_q <= retryCnt_d;
      pllRst_q   <= (state_d == RESET_PLL) || (state_d == FAULT);
      clkReady_q <= (state_d == RUN);
      fault_q    <= (state_d == FAULT);
    end
  end

  assign pll_rst   = pllRst_q;
  assign clk_ready = clkReady_q;
  assign fault     = fault_q;
  assign retry_cnt = retryCnt_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb_pll_lock_sequencer: directed scenarios plus randomized lock activity, checked
// every cycle against a behavioural model of the sequencing rules.
module tb_pll_lock_sequencer;

  localparam int RST_P = 4;
  localparam int TO    = 20;
  localparam int ST    = 8;
  localparam int MR    = 2;

  logic       refclk;
  logic       rst;
  logic       locked_in;
  logic       relock_req;
  logic       pll_rst;
  logic       clk_ready;
  logic       fault;
  logic [1:0] retry_cnt;

  int checks = 0;
  int errors = 0;

  // Behavioural model: phase name, cycles spent in the phase, retries used, and the
  // two-cycle delayed view of locked_in that the sequencer acts on.
  string mPhase   = "RESET";
  int    mAge     = 0;
  int    mRetries = 0;
  bit    mS1      = 1'b0;
  bit    mS2      = 1'b0;

  pll_lock_sequencer #(
    .RST_PULSE_CYC    (RST_P),
    .LOCK_TIMEOUT_CYC (TO),
    .LOCK_STABLE_CYC  (ST),
    .MAX_RETRIES      (MR)
  ) dut (
    .refclk     (refclk),
    .rst        (rst),
    .locked_in  (locked_in),
    .relock_req (relock_req),
    .pll_rst    (pll_rst),
    .clk_ready  (clk_ready),
    .fault      (fault),
    .retry_cnt  (retry_cnt)
  );

  // 50 MHz-style reference clock.
  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  // Guard against a hung run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic r, input logic lk, input logic rq);
    rst        = r;
    locked_in  = lk;
    relock_req = rq;
  endtask

  // Advance the model by one reference-clock edge using the inputs present at that edge.
  task automatic modelEdge();
    bit    seen;
    string nxt;
    seen = mS2;
    nxt  = mPhase;
    if (rst || relock_req) begin
      nxt      = "RESET";
      mRetries = 0;
    end else if (mPhase == "RESET") begin
      if (mAge == RST_P - 1) nxt = "WAIT";
    end else if (mPhase == "WAIT") begin
      if (seen) begin
        nxt = "STAB";
      end else if (mAge == TO - 1) begin
        if (mRetries == MR) begin
          nxt = "FAULT";
        end else begin
          mRetries = mRetries + 1;
          nxt      = "RESET";
        end
      end
    end else if (mPhase == "STAB") begin
      if (!seen) begin
        nxt = "WAIT";
      end else if (mAge == ST - 1) begin
        nxt      = "RUN";
        mRetries = 0;
      end
    end else if (mPhase == "RUN") begin
      if (!seen) nxt = "RESET";
    end
    if (rst || relock_req || (nxt != mPhase)) mAge = 0;
    else mAge = mAge + 1;
    mPhase = nxt;
    if (rst) begin
      mS1 = 1'b0;
      mS2 = 1'b0;
    end else begin
      mS2 = mS1;
      mS1 = locked_in;
    end
  endtask

  task automatic checkOutput(input string tag);
    logic expPll, expRdy, expFault;
    logic [1:0] expRetry;
    expPll   = (mPhase == "RESET") || (mPhase == "FAULT");
    expRdy   = (mPhase == "RUN");
    expFault = (mPhase == "FAULT");
    expRetry = 2'(mRetries);
    checks++;
    assert (pll_rst === expPll) else begin
      errors++;
      $error("[TB] FAIL %s pll_rst: observed %b expected %b", tag, pll_rst, expPll);
    end
    checks++;
    assert (clk_ready === expRdy) else begin
      errors++;
      $error("[TB] FAIL %s clk_ready: observed %b expected %b", tag, clk_ready, expRdy);
    end
    checks++;
    assert (fault === expFault) else begin
      errors++;
      $error("[TB] FAIL %s fault: observed %b expected %b", tag, fault, expFault);
    end
    checks++;
    assert (retry_cnt === expRetry) else begin
      errors++;
      $error("[TB] FAIL %s retry_cnt: observed %0d expected %0d", tag, retry_cnt, expRetry);
    end
  endtask

  task automatic checkScalar(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // One clock edge: update the model at the edge, compare outputs on the falling edge.
  task automatic tick(input string tag);
    @(posedge refclk);
    modelEdge();
    @(negedge refclk);
    checkOutput(tag);
  endtask

  // Width of a pll_rst pulse whose first high sample has just been observed.
  task automatic measurePulse(output int width);
    width = 1;
    for (int g = 0; g < 30 && pll_rst; g++) begin
      tick("pulse");
      if (pll_rst) width++;
    end
  endtask

  // Edges until clk_ready is seen high, bounded.
  task automatic waitReady(output int lat);
    lat = 0;
    for (int g = 0; g < 300 && !clk_ready; g++) begin
      tick("wait ready");
      lat++;
    end
  endtask

  initial begin
    int fallEdge, riseEdge, width, lat, hi, faultEdge, lowCycles, held, holdLeft;
    bit lockLevel;

    // Reset state
    applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (3) tick("reset");
    checkScalar("reset pll_rst", int'(pll_rst), 1);
    checkScalar("reset clk_ready", int'(clk_ready), 0);
    checkScalar("reset fault", int'(fault), 0);
    checkScalar("reset retry_cnt", int'(retry_cnt), 0);

    // Nominal lock: locked_in first sampled high at E+10 with E = edge 4
    fallEdge = -1;
    riseEdge = -1;
    for (int n = 1; n <= 40; n++) begin
      applyStimulus(1'b0, n >= RST_P + 10, 1'b0);
      tick("nominal");
      if (!pll_rst && fallEdge < 0) fallEdge = n;
      if (clk_ready && riseEdge < 0) riseEdge = n;
    end
    checkScalar("nominal pll_rst fall edge", fallEdge, RST_P);
    checkScalar("nominal clk_ready rise edge", riseEdge, RST_P + 10 + 2 + ST);
    checkScalar("nominal retry_cnt", int'(retry_cnt), 0);

    // Lock loss in RUN
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick("loss L");
    checkScalar("loss L clk_ready", int'(clk_ready), 1);
    tick("loss L+1");
    checkScalar("loss L+1 clk_ready", int'(clk_ready), 1);
    tick("loss L+2");
    checkScalar("loss L+2 clk_ready", int'(clk_ready), 0);
    checkScalar("loss L+2 pll_rst", int'(pll_rst), 1);
    measurePulse(width);
    checkScalar("loss pll_rst width", width, RST_P);
    applyStimulus(1'b0, 1'b1, 1'b0);
    waitReady(lat);
    checkScalar("loss requalify latency", lat, 1 + 2 + ST);

    // Relock request coincident with lock loss in RUN
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick("coincident L");
    tick("coincident L+1");
    applyStimulus(1'b0, 1'b0, 1'b1);
    tick("coincident L+2");
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkScalar("coincident pll_rst", int'(pll_rst), 1);
    checkScalar("coincident retry_cnt", int'(retry_cnt), 0);
    measurePulse(width);
    checkScalar("coincident pll_rst width", width, RST_P);
    hi = 0;
    repeat (10) begin
      tick("coincident after");
      if (pll_rst) hi++;
    end
    checkScalar("coincident single entry", hi, 0);

    // Dead PLL
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick("dead reset");
    applyStimulus(1'b0, 1'b0, 1'b0);
    faultEdge = -1;
    lowCycles = 0;
    for (int n = 1; n <= 150 && faultEdge < 0; n++) begin
      tick("dead");
      if (fault) faultEdge = n;
      else if (!pll_rst) lowCycles++;
    end
    checkScalar("dead fault edge", faultEdge, (MR + 1) * (RST_P + TO));
    checkScalar("dead wait cycles", lowCycles, (MR + 1) * TO);
    checkScalar("dead retry_cnt", int'(retry_cnt), MR);
    checkScalar("dead pll_rst", int'(pll_rst), 1);
    held = 0;
    repeat (200) begin
      tick("fault hold");
      if (fault && pll_rst && !clk_ready && retry_cnt == 2'(MR)) held++;
    end
    checkScalar("fault held cycles", held, 200);

    // Relock request in FAULT
    applyStimulus(1'b0, 1'b0, 1'b1);
    tick("relock");
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkScalar("relock fault", int'(fault), 0);
    checkScalar("relock retry_cnt", int'(retry_cnt), 0);
    checkScalar("relock pll_rst", int'(pll_rst), 1);
    measurePulse(width);
    checkScalar("relock pll_rst width", width, RST_P);

    // Glitch in STABILIZE: high sampled at edges 7..11, low at 12, high from 13
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick("glitch reset");
    hi = 0;
    riseEdge = -1;
    for (int n = 1; n <= 40; n++) begin
      applyStimulus(1'b0, (n >= 7 && n <= 11) || n >= 13, 1'b0);
      tick("glitch");
      if (n >= RST_P && pll_rst) hi++;
      if (clk_ready && riseEdge < 0) riseEdge = n;
    end
    checkScalar("glitch pll_rst pulses", hi, 0);
    checkScalar("glitch clk_ready rise edge", riseEdge, 13 + 2 + ST);

    // Reset in the middle of STABILIZE
    applyStimulus(1'b1, 1'b1, 1'b0);
    tick("mid reset pre");
    for (int n = 1; n <= 8; n++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      tick("mid stabilize");
    end
    applyStimulus(1'b1, 1'b1, 1'b0);
    tick("mid reset");
    checkScalar("mid reset pll_rst", int'(pll_rst), 1);
    checkScalar("mid reset clk_ready", int'(clk_ready), 0);
    checkScalar("mid reset fault", int'(fault), 0);
    checkScalar("mid reset retry_cnt", int'(retry_cnt), 0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    waitReady(lat);
    checkScalar("mid reset rerun latency", lat, RST_P + 1 + ST);

    // Randomized lock activity with occasional relock requests and resets
    holdLeft  = 0;
    lockLevel = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      if (holdLeft == 0) begin
        lockLevel = ~lockLevel;
        holdLeft  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(60, 160))
                                                : int'($urandom_range(1, 30));
      end
      holdLeft--;
      applyStimulus($urandom_range(0, 399) == 0, lockLevel, $urandom_range(0, 79) == 0);
      tick("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pll_lock_sequencer.md
# pll_lock_sequencer

Reset and lock sequencer for the pixel-clock PLL (50 MHz reference, 25.175 MHz VGA pixel clock). It runs on the PLL reference clock and drives the PLL reset. It qualifies the asynchronous `locked` output and issues a clean `clk_ready` that downstream pixel-domain reset logic uses as its release condition. It retries failed lock attempts, re-sequences on loss of lock, and latches a fault after a bounded number of retries.

## Interface
Parameters:
- `RST_PULSE_CYC`, default 16: PLL reset pulse width, in `refclk` cycles.
- `LOCK_TIMEOUT_CYC`, default 50000: maximum cycles in WAIT_LOCK (1 ms at 50 MHz).
- `LOCK_STABLE_CYC`, default 1024: consecutive synchronized-lock cycles required before `clk_ready`.
- `MAX_RETRIES`, default 3: re-reset attempts after timeout before FAULT.

Ports:
- `refclk`  in  1  50 MHz reference clock; the only clock.
- `rst`  in  1  Synchronous, active-high reset; highest priority.
- `locked_in`  in  1  PLL `locked` output; asynchronous to `refclk`.
- `relock_req`  in  1  Single-cycle request to restart the sequence; clears retries.
- `pll_rst`  out  1  Reset to the PLL.
- `clk_ready`  out  1  Pixel clock qualified stable.
- `fault`  out  1  Retries exhausted.
- `retry_cnt`  out  $clog2(MAX_RETRIES+1)  Retries used in the current sequence.

## Operation
- **Input synchronizer.** `locked_in` passes through a 2-flop synchronizer; both flops reset to 0. The FSM sees only `lock_sync`.
- **Cycle counter.** One shared counter, wide enough for the largest parameter. It clears on every state transition and increments every cycle otherwise.
- **State machine.** States are RESET_PLL, WAIT_LOCK, STABILIZE, RUN, FAULT. Priority order is `rst` > `relock_req` > the state rules below.
  - `rst`: go to RESET_PLL; counter = 0, `retry_cnt` = 0.
  - RESET_PLL: when counter == RST_PULSE_CYC-1, go to WAIT_LOCK.
  - WAIT_LOCK, lock found: if `lock_sync` = 1, go to STABILIZE.
  - WAIT_LOCK, timeout: if counter == LOCK_TIMEOUT_CYC-1 and no lock:
    - if `retry_cnt` == MAX_RETRIES, go to FAULT;
    - otherwise increment `retry_cnt` and go to RESET_PLL.
  - STABILIZE, lock lost: if `lock_sync` = 0, go to WAIT_LOCK. The timeout restarts; `retry_cnt` is unchanged.
  - STABILIZE, lock held: if counter == LOCK_STABLE_CYC-1 and `lock_sync` = 1, go to RUN.
  - RUN: `retry_cnt` clears on entry. If `lock_sync` = 0, go to RESET_PLL.
  - FAULT: terminal. The only exits are `rst` or `relock_req`.
  - `relock_req` in any state: go to RESET_PLL with counter = 0 and `retry_cnt` = 0.
  - Simultaneous lock loss and `relock_req` in RUN: exactly one RESET_PLL entry, with `retry_cnt` = 0.
- **Outputs.** All outputs are registered Moore outputs of the state.
  - `pll_rst` = 1 in RESET_PLL and FAULT (the PLL stays held in reset while faulted).
  - `clk_ready` = 1 only in RUN.
  - `fault` = 1 only in FAULT.
- **Reset values.** `pll_rst` = 1, `clk_ready` = 0, `fault` = 0, `retry_cnt` = 0.

## Timing
- **Reset pulse width.** `pll_rst` stays high for exactly RST_PULSE_CYC cycles after `rst` deasserts, and for exactly RST_PULSE_CYC cycles on every retry or relock.
- **Lock-acquire latency.** Let `locked_in` be first sampled high at edge E+k, where E is the edge on which WAIT_LOCK is entered (the edge `pll_rst` falls).
  - `lock_sync` goes high after edge E+k+1.
  - STABILIZE is entered at edge E+k+2.
  - `clk_ready` rises at edge E+k+2+LOCK_STABLE_CYC, provided lock holds throughout.
- **Lock-loss latency.** When `locked_in` is sampled low at edge L in RUN, `clk_ready` falls and `pll_rst` rises at edge L+2.
- **Retry window.** Each WAIT_LOCK without lock lasts exactly LOCK_TIMEOUT_CYC cycles. With a dead PLL, FAULT is entered after MAX_RETRIES+1 timeouts.
- **Reset mid-operation.** `rst` high at any edge yields reset values on all outputs after that edge.

## Structure
- **Package `pll_seq_pkg`.** Holds the state enum typedef and a helper function that computes the counter width from the parameters.
- **Sub-module `sync_2ff`.** A single-bit 2-flop synchronizer with synchronous active-high reset, so it can be reused for other PLL status bits.
- **Top level.** The FSM, counter and retry register live in the top module.

## Test plan
All scenarios use RST_PULSE_CYC=4, LOCK_TIMEOUT_CYC=20, LOCK_STABLE_CYC=8, MAX_RETRIES=2.
- **Nominal lock.** Release `rst`; the PLL model samples `locked_in` high at E+10 -> `pll_rst` high for exactly 4 cycles, then `clk_ready` rises at E+20, `retry_cnt` = 0, `fault` = 0.
- **Dead PLL.** `locked_in` is held at 0 -> 3 `pll_rst` pulses of 4 cycles each, each followed by a 20-cycle WAIT_LOCK. Then `fault` = 1, `pll_rst` is held at 1, `retry_cnt` = 2, and the outputs stay there for 200 more cycles.
- **Glitch in STABILIZE.** `locked_in` goes high for 5 cycles, then low for 1 cycle, then high steadily -> no `clk_ready` during the glitch and no new `pll_rst` pulse. `clk_ready` rises 10 cycles after the final rise is sampled.
- **Lock loss in RUN.** Drop `locked_in` at edge L -> `clk_ready` = 0 and `pll_rst` = 1 at L+2. The `pll_rst` pulse lasts 4 cycles, and `clk_ready` returns once lock is re-qualified.
- **Relock request.** `relock_req` in FAULT -> `fault` = 0 next cycle, `retry_cnt` = 0, a new 4-cycle `pll_rst` pulse. `relock_req` coincident with lock loss in RUN -> exactly one RESET_PLL entry.
- **Reset mid-sequence.** `rst` asserted in the middle of STABILIZE -> after the next edge `pll_rst` = 1, `clk_ready` = 0, `fault` = 0, `retry_cnt` = 0. The full sequence reruns after release.
